// File: rtl/confreg_pkg.sv
// Shared constants for the confreg response block:
// register offsets, widths and the default base page.
package confreg_pkg;

    localparam logic [15:0] BASE_HI_DEF = 16'hBFAF;

    localparam int DATA_W = 32;
    localparam int LED_W  = 16;
    localparam int SW_W   = 8;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_NUM     = 16'h0004;
    localparam logic [15:0] OFF_SWITCH  = 16'h0008;
    localparam logic [15:0] OFF_TIMER   = 16'h000C;
    localparam logic [15:0] OFF_SCRATCH = 16'h0010;
    localparam logic [15:0] OFF_CMP     = 16'h0014;
    localparam logic [15:0] OFF_STATUS  = 16'h0018;

    typedef enum logic [2:0] {
        SEL_LED,
        SEL_NUM,
        SEL_SWITCH,
        SEL_TIMER,
        SEL_SCRATCH,
        SEL_CMP,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Map a word-aligned offset onto a register select.
    function automatic reg_sel_e decode_off(input logic [15:0] off);
        reg_sel_e s;
        s = SEL_NONE;
        unique case (1'b1)
            off == OFF_LED:     s = SEL_LED;
            off == OFF_NUM:     s = SEL_NUM;
            off == OFF_SWITCH:  s = SEL_SWITCH;
            off == OFF_TIMER:   s = SEL_TIMER;
            off == OFF_SCRATCH: s = SEL_SCRATCH;
            off == OFF_CMP:     s = SEL_CMP;
            off == OFF_STATUS:  s = SEL_STATUS;
            default:            s = SEL_NONE;
        endcase
        return s;
    endfunction

    // Byte-lane merge of write data into an existing word.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        we
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cfg_sync2.sv
// Two-flop synchronizer for the board switch inputs.
// Both stages clear on reset.
module cfg_sync2
    import confreg_pkg::*;
#(
    parameter int W = SW_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // Shift the asynchronous input through two stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/confreg_resp.sv
// Config register block on the data SRAM port:
// LED/NUM/SWITCH/TIMER/SCRATCH/CMP/STATUS with 1-cycle reads.
module confreg_resp
    import confreg_pkg::*;
#(
    parameter logic [15:0] BASE_HI   = BASE_HI_DEF,
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    input  logic [SW_W-1:0]   switch_in,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       num_data,
    output logic              timer_irq
);

    logic [LED_W-1:0]  led_q;
    logic [31:0]       num_q;
    logic [31:0]       timer_q;
    logic [31:0]       scratch_q;
    logic [31:0]       cmp_q;
    logic              status_q;
    logic [SW_W-1:0]   sw_q;

    logic              hit;
    logic              rd_req;
    logic              wr_req;
    reg_sel_e          sel;
    logic [31:0]       rd_val;
    logic [LED_W-1:0]  led_m;
    logic              match;
    logic              clr;

    // Byte offset bits are don't-care for word registers.
    logic unused_addr_lo;
    assign unused_addr_lo = ^data_sram_addr[1:0];

    assign hit    = data_sram_en &&
                    (data_sram_addr[31:16] == BASE_HI);
    assign rd_req = data_sram_en && (data_sram_we == 4'b0000);
    assign wr_req = hit && (data_sram_we != 4'b0000);

    cfg_sync2 #(.W(SW_W)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (switch_in),
        .q      (sw_q)
    );

    // Decode and read mux; misses select nothing and read 0.
    always_comb begin
        sel    = SEL_NONE;
        rd_val = '0;
        if (hit) sel = decode_off({data_sram_addr[15:2], 2'b00});
        unique case (sel)
            SEL_LED:     rd_val = {16'h0, led_q};
            SEL_NUM:     rd_val = num_q;
            SEL_SWITCH:  rd_val = {24'h0, sw_q};
            SEL_TIMER:   rd_val = timer_q;
            SEL_SCRATCH: rd_val = scratch_q;
            SEL_CMP:     rd_val = cmp_q;
            SEL_STATUS:  rd_val = {31'h0, status_q};
            default:     rd_val = '0;
        endcase
    end

    // LED only has the two low byte lanes.
    always_comb begin
        led_m = led_q;
        if (data_sram_we[0]) led_m[7:0]  = data_sram_wdata[7:0];
        if (data_sram_we[1]) led_m[15:8] = data_sram_wdata[15:8];
    end

    assign match = (timer_q == cmp_q);
    assign clr   = wr_req && (sel == SEL_STATUS) &&
                   data_sram_we[0] && data_sram_wdata[0];

    // Read data captures the pre-edge register value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= '0;
        end else if (rd_req) begin
            data_sram_rdata <= rd_val;
        end
    end

    // Plain read/write registers with byte-lane writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q     <= '0;
            num_q     <= '0;
            scratch_q <= '0;
            cmp_q     <= '0;
        end else if (wr_req) begin
            unique case (sel)
                SEL_LED:     led_q <= led_m;
                SEL_NUM:     num_q <= lane_merge(num_q,
                                data_sram_wdata, data_sram_we);
                SEL_SCRATCH: scratch_q <= lane_merge(scratch_q,
                                data_sram_wdata, data_sram_we);
                SEL_CMP:     cmp_q <= lane_merge(cmp_q,
                                data_sram_wdata, data_sram_we);
                default:     ;
            endcase
        end
    end

    // Free-running timer; a write overrides the increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= TIMER_RST;
        end else if (wr_req && sel == SEL_TIMER) begin
            timer_q <= lane_merge(timer_q,
                           data_sram_wdata, data_sram_we);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Sticky match flag; a set in the same cycle beats a clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= 1'b0;
        end else begin
            status_q <= match | (status_q & ~clr);
        end
    end

    assign led       = led_q;
    assign num_data  = num_q;
    assign timer_irq = status_q;

endmodule

// File: tb/tb_confreg_resp.sv
// Randomized and directed bench for confreg_resp
// against a register-level reference model.
module tb_confreg_resp;

    localparam logic [15:0] BASE = 16'hBFAF;
    localparam logic [31:0] TRST = 32'h0000_0010;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_irq;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [15:0] m_led;
    logic [31:0] m_num, m_scr, m_cmp, m_tmr, m_rd;
    logic        m_stat;
    logic [7:0]  m_s1, m_s2;

    confreg_resp #(.BASE_HI(BASE), .TIMER_RST(TRST)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led             (led),
        .num_data        (num_data),
        .timer_irq       (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
        input logic [31:0] n, input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_led = '0; m_num = '0; m_scr = '0; m_cmp = '0;
        m_tmr = TRST; m_rd = '0; m_stat = 1'b0;
        m_s1 = '0; m_s2 = '0;
    endtask

    // One bus cycle: drive at negedge, model the edge, compare after it.
    task automatic step(input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic        hit, wr, clr;
        logic [15:0] off;
        logic [31:0] rv, t;
        logic [15:0] n_led;
        logic [31:0] n_num, n_scr, n_cmp, n_tmr, n_rd;
        logic        n_stat;
        @(negedge clk);
        data_sram_en = en; data_sram_we = we;
        data_sram_addr = addr; data_sram_wdata = wd;
        hit = en && (addr[31:16] == BASE);
        off = {addr[15:2], 2'b00};
        wr  = hit && (we != 4'b0);
        rv  = '0;
        if (hit) begin
            case (off)
                16'h00: rv = {16'h0, m_led};
                16'h04: rv = m_num;
                16'h08: rv = {24'h0, m_s2};
                16'h0C: rv = m_tmr;
                16'h10: rv = m_scr;
                16'h14: rv = m_cmp;
                16'h18: rv = {31'h0, m_stat};
                default: rv = '0;
            endcase
        end
        n_rd  = (en && we == 4'b0) ? rv : m_rd;
        n_led = m_led; n_num = m_num; n_scr = m_scr; n_cmp = m_cmp;
        if (wr && off == 16'h00) begin
            t = merge({16'h0, m_led}, wd, we);
            n_led = t[15:0];
        end
        if (wr && off == 16'h04) n_num = merge(m_num, wd, we);
        if (wr && off == 16'h10) n_scr = merge(m_scr, wd, we);
        if (wr && off == 16'h14) n_cmp = merge(m_cmp, wd, we);
        n_tmr = (wr && off == 16'h0C) ? merge(m_tmr, wd, we)
                                      : m_tmr + 32'd1;
        clr    = wr && off == 16'h18 && we[0] && wd[0];
        n_stat = (m_tmr == m_cmp) || (m_stat && !clr);
        @(posedge clk);
        #1;
        m_led = n_led; m_num = n_num; m_scr = n_scr; m_cmp = n_cmp;
        m_tmr = n_tmr; m_rd = n_rd; m_stat = n_stat;
        m_s2 = m_s1; m_s1 = switch_in;
        chk("rdata", data_sram_rdata, m_rd);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("num", num_data, m_num);
        chk("irq", {31'h0, timer_irq}, {31'h0, m_stat});
    endtask

    function automatic logic [31:0] ad(input logic [15:0] off);
        return {BASE, off};
    endfunction

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [15:0] off);
        step(1'b1, 4'h0, ad(off), 32'h0);
    endtask

    task automatic wr(input logic [15:0] off, input logic [3:0] we,
                      input logic [31:0] wd);
        step(1'b1, we, ad(off), wd);
    endtask

    initial begin
        int guard;
        logic [15:0] offs [10];
        offs = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10,
                 16'h14, 16'h18, 16'h1C, 16'h40, 16'h00};

        resetn = 1'b0;
        data_sram_en = 0; data_sram_we = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        switch_in = 8'h00;
        model_reset();
        #12;
        chk("rst_rdata", data_sram_rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_num", num_data, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        #2 resetn = 1'b1;

        // timer starts from its reset value
        rd(16'h0C);
        chk("tmr_first", data_sram_rdata, TRST);
        rd(16'h0C);
        chk("tmr_second", data_sram_rdata, TRST + 32'd1);

        // byte-lane write to scratch
        wr(16'h10, 4'b0101, 32'hAABBCCDD);
        rd(16'h10);
        chk("scr_lanes", data_sram_rdata, 32'h00BB00DD);

        // timer wrap and back-to-back write/read
        wr(16'h0C, 4'hF, 32'hFFFFFFFE);
        rd(16'h0C);
        chk("tmr_wr_rd", data_sram_rdata, 32'hFFFFFFFE);
        rd(16'h0C);
        chk("tmr_ff", data_sram_rdata, 32'hFFFFFFFF);
        rd(16'h0C);
        chk("tmr_wrap", data_sram_rdata, 32'h00000000);
        wr(16'h0C, 4'hF, 32'hCAFE0000);
        rd(16'h0C);
        chk("tmr_b2b", data_sram_rdata, 32'hCAFE0000);

        // decode: miss, switch write ignored, switch sync
        rd(16'h10);
        step(1'b1, 4'h0, 32'hBFB00000, 32'h0);
        chk("miss_rd", data_sram_rdata, 32'h0);
        switch_in = 8'h5A;
        idle();
        idle();
        wr(16'h08, 4'hF, 32'hFFFFFFFF);
        rd(16'h08);
        chk("sw_sync", data_sram_rdata, 32'h5A);
        rd(16'h1C);
        chk("unmapped", data_sram_rdata, 32'h0);

        // rdata holds across idles and writes
        wr(16'h04, 4'hF, 32'h12345678);
        rd(16'h04);
        chk("num_rd", data_sram_rdata, 32'h12345678);
        idle(); idle(); idle();
        wr(16'h10, 4'hF, 32'h0BADF00D);
        chk("rd_hold", data_sram_rdata, 32'h12345678);

        // compare match, set-over-clear priority
        wr(16'h14, 4'hF, 32'h100);
        wr(16'h0C, 4'hF, 32'hF0);
        wr(16'h18, 4'h1, 32'h1);
        chk("irq_clr", {31'h0, timer_irq}, 32'h0);
        guard = 0;
        while (m_tmr != 32'h100 && guard < 64) begin
            idle();
            guard++;
        end
        chk("match_wait", guard < 64, 1'b1);
        wr(16'h18, 4'h1, 32'h1);
        chk("irq_set_pri", {31'h0, timer_irq}, 32'h1);
        wr(16'h18, 4'h1, 32'h1);
        chk("irq_w1c", {31'h0, timer_irq}, 32'h0);

        // reset in the middle of a read
        wr(16'h00, 4'h3, 32'h0000BEEF);
        @(negedge clk);
        data_sram_en = 1; data_sram_we = 0;
        data_sram_addr = ad(16'h04);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("mid_rdata", data_sram_rdata, 32'h0);
        chk("mid_led", {16'h0, led}, 32'h0);
        chk("mid_num", num_data, 32'h0);
        chk("mid_irq", {31'h0, timer_irq}, 32'h0);
        data_sram_en = 0;
        @(posedge clk);
        #2 resetn = 1'b1;
        switch_in = 8'h00;
        model_reset();
        idle();
        chk("post_rdata", data_sram_rdata, 32'h0);
        rd(16'h0C);
        chk("post_tmr", data_sram_rdata, TRST + 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, d;
            logic [3:0]  we;
            int k;
            k = $urandom_range(0, 9);
            a = {BASE, offs[k][15:2], 2'($urandom_range(0, 3))};
            if (k == 9) a[31:16] = 16'hBFB0;
            we = ($urandom_range(0, 1) == 0) ? 4'h0
                                              : 4'($urandom_range(0, 15));
            d = $urandom;
            if (k == 5 && $urandom_range(0, 2) == 0)
                d = m_tmr + 32'($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0)
                switch_in = 8'($urandom);
            step($urandom_range(0, 4) != 0, we, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
